instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Upstream instruction-issue stage for the bus processor's control FSM. It holds a small loadable program memory, steps a program counter, and decodes each word into func/rx/ry/data. It hands each instruction to the control block with a one-cycle w pulse and waits for that block's done before fetching the next word. Halts on a HALT opcode.

Parameters:
ADDR_W, 6, program memory address width (64 words).
IW, 16, instruction word width.
DATA_W, 32, processor bus / immediate width.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  start or restart execution from IDLE/HALT
load_en  in  1  program-memory write strobe, honoured only in IDLE/HALT
load_addr  in  ADDR_W  program-memory write address
load_data  in  IW  program-memory write data
done  in  1  control FSM finished current instruction (1-cycle pulse)
w  out  1  instruction-valid pulse to control FSM
func  out  3  opcode to control FSM
rx  out  4  destination register index (R0-R15)
ry  out  4  source register index (R0-R15)
data  out  DATA_W  immediate for MVI, zero-extended
pc  out  ADDR_W  current program counter
busy  out  1  executing a program
halted  out  1  HALT opcode reached

Behaviour:
- Instruction word: [15:13] func, [12:9] rx, [8:5] ry, [4:0] ignored. Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 XOR, 111 HALT (consumed locally, never issued); 101/110 issued unchanged.
- MVI is two words: the opcode word, then its immediate word at pc+1; data = {(DATA_W-IW) zeros, word}.
- Reset: state IDLE; pc=0; w=0; func=0; rx=0; ry=0; data=0; busy=0; halted=0. Memory contents are not cleared.
- Memory: synchronous read, 1-cycle latency; write on load_en in IDLE/HALT only. load_en in any other state is ignored.
- States:
  - IDLE: run=1 and load_en=0 -> FETCH, busy=1. If run and load_en are both 1, the load wins and run is ignored.
  - FETCH: present pc to memory -> DECODE.
  - DECODE: latch func/rx/ry. func=111 -> HALT. func=001 -> IMM_FETCH with pc<=pc+1. Otherwise data<=0 -> ISSUE.
  - IMM_FETCH: one read cycle -> IMM_LATCH.
  - IMM_LATCH: latch data -> ISSUE.
  - ISSUE: w=1 for exactly this cycle -> WAIT.
  - WAIT: on done=1, pc<=pc+1 -> FETCH. done is sampled only in WAIT; a done in any other state is ignored.
  - HALT: halted=1, busy=0, w=0. run=1 clears halted, sets pc<=0, busy<=1 -> FETCH. Loads are allowed in HALT.
- func/rx/ry/data are stable from the ISSUE cycle until the cycle after done.
- Latency: w rises 2 cycles after entering FETCH for a non-MVI instruction, 4 cycles for MVI. Next FETCH starts the cycle after done.
- PC wraps modulo 2^ADDR_W: 63+1=0. An MVI at address 63 takes its immediate from address 0.
- A reset asserted in any state overrides everything next edge. A pending done is discarded.

Decomposition:
- Shared package: opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_XOR, OP_HALT), instruction field bit positions, state encoding.
- Sub-module prog_mem: single-port synchronous RAM, separate write port for loading; read address muxed from pc.

Test Plan:
- Reset then idle: all outputs 0, pc=0; run with load_en=1 -> no start, word written.
- Load [0]=0x4600 (ADD R3,R0), [1]=0xE000 (HALT); run; done 3 cycles after w -> single w pulse with func=2, rx=3, ry=0; then halted=1, busy=0, pc=1.
- MVI: [0]=0x2200 (MVI R1), [1]=0x00AB, [2]=HALT -> w with func=1, rx=1, data=0x000000AB; pc=2 at halt.
- done held 0 for 20 cycles in WAIT -> w stays 0, outputs stable, pc unchanged. Spurious done during FETCH is ignored.
- Wrap: MVI at 63, immediate 0x1234 at 0, HALT at 1 -> data=0x00001234, halts at pc=1.
- Reset asserted in WAIT -> next cycle IDLE, outputs 0, memory preserved; run re-executes the same program identically.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, word fields, FSM states.
package instr_sequencer_pkg;

  // Opcodes carried in the top three bits of an instruction word
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Instruction word field positions; bits [4:0] carry nothing
  localparam int FUNC_HI = 15;
  localparam int FUNC_LO = 13;
  localparam int RX_HI   = 12;
  localparam int RX_LO   = 9;
  localparam int RY_HI   = 8;
  localparam int RY_LO   = 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_IMM_FETCH = 3'd3,
    S_IMM_LATCH = 3'd4,
    S_ISSUE     = 3'd5,
    S_WAIT      = 3'd6,
    S_HALT      = 3'd7
  } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Issue handshake between the sequencer (master) and the control FSM (slave).
interface instr_sequencer_if #(
  parameter int DATA_W = 32
) ();
  logic              w;
  logic [2:0]        func;
  logic [3:0]        rx;
  logic [3:0]        ry;
  logic [DATA_W-1:0] data;
  logic              done;

  modport master (output w, output func, output rx, output ry, output data, input done);
  modport slave  (input w, input func, input rx, input ry, input data, output done);
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: synchronous read (1-cycle latency) plus an independent load write port.
module instr_sequencer_prog_mem #(
  parameter int ADDR_W = 6,
  parameter int IW     = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [IW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [IW-1:0]     rdata
);

  logic [IW-1:0] mem_q [2**ADDR_W];
  logic [IW-1:0] rdata_d;
  logic [IW-1:0] rdata_q;

  // Read the addressed word combinationally; it is registered below
  always_comb rdata_d = mem_q[raddr];

  // Load writes and registered read; contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from program memory, decodes, issues to the
// control FSM with a one-cycle w pulse and waits for done; stops on HALT.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int IW     = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [IW-1:0]       load_data,
  instr_sequencer_if.master   ctl,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        func_q, func_d;
  logic [3:0]        rx_q, rx_d;
  logic [3:0]        ry_q, ry_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     rdata;
  logic              mem_we;

  // Loads are only accepted while no program is running
  assign mem_we = load_en && ((state_q == S_IDLE) || (state_q == S_HALT));

  instr_sequencer_prog_mem #(
    .ADDR_W (ADDR_W),
    .IW     (IW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (rdata)
  );

  // State and decoded-field registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      func_q  <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      func_q  <= func_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      data_q  <= data_d;
    end
  end

  // Next-state, PC stepping and field latching
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    func_d  = func_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        // A simultaneous load takes priority over starting
        if (run && !load_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        // pc_q is already the memory read address; word is valid next cycle
        state_d = S_DECODE;
      end
      S_DECODE: begin
        func_d = rdata[FUNC_HI:FUNC_LO];
        rx_d   = rdata[RX_HI:RX_LO];
        ry_d   = rdata[RY_HI:RY_LO];
        if (rdata[FUNC_HI:FUNC_LO] == OP_HALT) begin
          state_d = S_HALT;
        end else if (rdata[FUNC_HI:FUNC_LO] == OP_MVI) begin
          // Immediate lives in the next word; pc wraps naturally
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_IMM_FETCH;
        end else begin
          data_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_IMM_FETCH: state_d = S_IMM_LATCH;
      S_IMM_LATCH: begin
        data_d  = DATA_W'(rdata);
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (ctl.done) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (run) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ctl.w    = (state_q == S_ISSUE);
  assign ctl.func = func_q;
  assign ctl.rx   = rx_q;
  assign ctl.ry   = ry_q;
  assign ctl.data = data_q;
  assign pc       = pc_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted   = (state_q == S_HALT);

endmodule
